// File: rtl/dsp_pkg.sv
// Shared constants for the sample-rate-change datapath blocks.
package dsp_pkg;

  localparam int  DSP_DATA_W = 18;

  localparam logic MODE_PICK = 1'b0;
  localparam logic MODE_AVG  = 1'b1;

endpackage

// File: rtl/decim_phase_counter.sv
// Frame position counter for integer-factor rate changers.
// Counts accepted samples 0..FACTOR-1 and exposes the index of the sample
// currently being presented, with sync forcing that index to 0.
module decim_phase_counter
  import dsp_pkg::*;
#(
  parameter int FACTOR = 4,
  localparam int CNT_W = $clog2(FACTOR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clk_en,
  input  logic             sync,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] idx,
  output logic             frame_start,
  output logic             frame_end
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FACTOR - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  // Index of the sample on x_in this cycle; sync makes it the first of a new frame.
  assign idx         = sync ? '0 : cnt;
  assign frame_start = sync | (clk_en & (cnt == '0));
  assign frame_end   = clk_en & (idx == LAST);

  // Sample counter: restart on sync, otherwise advance and wrap on accepted samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (sync) begin
      cnt <= clk_en ? ONE : '0;
    end else if (clk_en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/decimator_r.sv
// Integer-factor decimator: pick one sample per frame or output the frame mean.
// mode/phase are sampled at each frame start so a frame is always processed
// with one consistent setting; the current sample uses the incoming setting
// when it is itself the first sample of a frame.
module decimator_r
  import dsp_pkg::*;
#(
  parameter int DATA_W = DSP_DATA_W,
  parameter int FACTOR = 4,
  localparam int CNT_W = $clog2(FACTOR),
  localparam int ACC_W = DATA_W + CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clk_en,
  input  logic [DATA_W-1:0] x_in,
  input  logic              mode,
  input  logic [CNT_W-1:0]  phase,
  input  logic              sync,
  output logic [DATA_W-1:0] y,
  output logic              y_valid
);

  generate
    if (FACTOR < 2 || (FACTOR & (FACTOR - 1)) != 0) begin : g_bad_factor
      $error("decimator_r: FACTOR must be a power of two >= 2");
    end
  endgenerate

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] idx;
  logic             frame_start;
  logic             frame_end;

  logic             mode_q;
  logic [CNT_W-1:0] phase_q;
  logic             mode_eff;
  logic [CNT_W-1:0] phase_eff;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] x_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    pick_hit;
  logic                    avg_hit;

  decim_phase_counter #(
    .FACTOR (FACTOR)
  ) u_cnt (
    .clk         (clk),
    .reset       (reset),
    .clk_en      (clk_en),
    .sync        (sync),
    .cnt         (cnt),
    .idx         (idx),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  // Settings that govern the current sample.
  assign mode_eff  = frame_start ? mode  : mode_q;
  assign phase_eff = frame_start ? phase : phase_q;

  // Running frame sum including the current sample; the first sample of a frame discards old state.
  assign x_ext    = ACC_W'(signed'(x_in));
  assign acc_base = (idx == '0) ? '0 : acc;
  assign sum      = acc_base + x_ext;

  assign pick_hit = clk_en & (mode_eff == MODE_PICK) & (idx == phase_eff);
  assign avg_hit  = (mode_eff == MODE_AVG) & frame_end;

  // Capture mode/phase at each frame start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= MODE_PICK;
      phase_q <= '0;
    end else if (frame_start) begin
      mode_q  <= mode;
      phase_q <= phase;
    end
  end

  // Accumulator: builds the frame sum in average mode, cleared at frame end and on idle sync.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc <= '0;
    end else if (clk_en) begin
      if (mode_eff == MODE_AVG && !frame_end) begin
        acc <= sum;
      end else begin
        acc <= '0;
      end
    end else if (sync) begin
      acc <= '0;
    end
  end

  // Output register and one-cycle valid; dropping the low CNT_W bits is a floor divide.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y       <= '0;
      y_valid <= 1'b0;
    end else begin
      y_valid <= pick_hit | avg_hit;
      if (pick_hit) begin
        y <= x_in;
      end else if (avg_hit) begin
        y <= sum[ACC_W-1:CNT_W];
      end
    end
  end

endmodule

// File: tb/tb_decimator_r.sv
// Directed bench for decimator_r with FACTOR=4, DATA_W=18.
module tb_decimator_r;

  localparam int DATA_W = 18;
  localparam int FACTOR = 4;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              reset;
  logic              clk_en;
  logic [DATA_W-1:0] x_in;
  logic              mode;
  logic [CNT_W-1:0]  phase;
  logic              sync;
  logic [DATA_W-1:0] y;
  logic              y_valid;

  int n_checks = 0;
  int n_errors = 0;

  decimator_r #(
    .DATA_W (DATA_W),
    .FACTOR (FACTOR)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .clk_en  (clk_en),
    .x_in    (x_in),
    .mode    (mode),
    .phase   (phase),
    .sync    (sync),
    .y       (y),
    .y_valid (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Present one input for one clock, then settle just after the edge.
  task automatic step(input logic en, input int x);
    clk_en = en;
    x_in   = DATA_W'(x);
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input int exp_y, input logic exp_v);
    check({tag, "_y"}, $signed(y), exp_y);
    check({tag, "_v"}, {31'b0, y_valid}, {31'b0, exp_v});
  endtask

  int exp_y;
  int vcount;

  initial begin
    reset  = 1'b0;
    clk_en = 1'b0;
    x_in   = '0;
    mode   = 1'b0;
    phase  = '0;
    sync   = 1'b0;

    // Reset held while samples arrive
    #1;
    step(1'b1, 1000);
    step(1'b1, 1000);
    step(1'b1, 1000);
    check_out("rst_hold", 0, 1'b0);
    reset = 1'b1;
    step(1'b1, 7);
    check_out("rst_first_pick", 7, 1'b1);
    step(1'b1, 8);
    check_out("rst_second", 7, 1'b0);
    step(1'b1, 9);
    step(1'b1, 10);

    // Pick, phase 2, continuous clk_en
    phase = 2'd2;
    exp_y = 7;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, i);
      if (i % 4 == 2) exp_y = i;
      check_out($sformatf("pick_ph2_%0d", i), exp_y, (i % 4 == 2));
    end

    // Average with floor rounding, then full-scale positive
    mode = 1'b1;
    step(1'b1, -3);
    step(1'b1, -2);
    step(1'b1, -1);
    check_out("avg_mid", 10, 1'b0);
    step(1'b1, 1);
    check_out("avg_floor", -2, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 131071);
    check_out("avg_max", 131071, 1'b1);

    // Phase change mid-frame takes effect next frame
    mode  = 1'b0;
    phase = 2'd1;
    step(1'b1, 20);
    check_out("ph_chg_s0", 131071, 1'b0);
    phase = 2'd3;
    step(1'b1, 21);
    check_out("ph_chg_s1", 21, 1'b1);
    step(1'b1, 22);
    step(1'b1, 23);
    check_out("ph_chg_s3_old", 21, 1'b0);
    step(1'b1, 30);
    step(1'b1, 31);
    step(1'b1, 32);
    check_out("ph_chg_next_s2", 21, 1'b0);
    step(1'b1, 33);
    check_out("ph_chg_next_s3", 33, 1'b1);

    // Sync with clk_en mid-frame in average mode
    mode = 1'b1;
    step(1'b1, 100);
    step(1'b1, 100);
    sync = 1'b1;
    step(1'b1, 8);
    sync = 1'b0;
    check_out("sync_en_s0", 33, 1'b0);
    step(1'b1, 4);
    step(1'b1, 4);
    check_out("sync_en_s2", 33, 1'b0);
    step(1'b1, 4);
    check_out("sync_en_avg", 5, 1'b1);

    // Reset mid-frame discards partial sum
    step(1'b1, 100);
    step(1'b1, 100);
    reset = 1'b0;
    #1;
    check_out("rst_mid_async", 0, 1'b0);
    step(1'b0, 0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b1, 8);
    check_out("rst_mid_partial", 0, 1'b0);
    step(1'b1, 8);
    check_out("rst_mid_avg", 8, 1'b1);

    // Sync without clk_en: y holds, frame restarts
    mode  = 1'b0;
    phase = 2'd0;
    step(1'b1, 50);
    check_out("sync_idle_pre", 50, 1'b1);
    step(1'b1, 51);
    sync = 1'b1;
    step(1'b0, 77);
    sync = 1'b0;
    check_out("sync_idle_hold", 50, 1'b0);
    step(1'b1, 60);
    check_out("sync_idle_restart", 60, 1'b1);
    step(1'b1, 61);
    step(1'b1, 62);
    step(1'b1, 63);

    // Gapped clk_en (1 in 3), pick phase 0
    exp_y  = 60;
    vcount = 0;
    for (int c = 0; c < 24; c++) begin
      logic en;
      logic ev;
      en = (c % 3 == 0);
      ev = en && ((c / 3) % 4 == 0);
      step(en, en ? 200 + c / 3 : 999);
      if (ev) exp_y = 200 + c / 3;
      if (y_valid) vcount++;
      check_out($sformatf("gap_%0d", c), exp_y, ev);
    end
    check("gap_pulse_count", vcount, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
